// File: rtl/fetch_frontend_pkg.sv
// Shared types and constants for the instruction-fetch frontend.
// Holds the default address width and the buffered fetch entry layout.
package fetch_frontend_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ibuf.sv
// Synchronous instruction FIFO with flush; head read is zero when empty.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: caller must not push when full; pop on empty is ignored.
module fetch_ibuf
    import fetch_frontend_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  entry_t                       push_dat_i,
    input  logic                         pop_i,
    output logic                         head_vld_o,
    output entry_t                       head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           pop_eff;

    assign pop_eff = pop_i && (count_q != '0);

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_eff})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_vld_o = (count_q != '0);
    assign head_dat_o = head_vld_o ? mem[rd_ptr_q] : '0;
    assign count_o    = count_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn)
        (push_i && !flush_i) |-> (count_q < CW'(DEPTH)));

endmodule

// File: rtl/fetch_frontend.sv
// Sequential-PC fetch frontend: credit-limited I-cache requests feeding an instruction FIFO.
// Latency: address fire at t, response at t+k, instruction valid at t+k+1.
// Backpressure: decoder stall fills the FIFO, credits run out and request issue stops.
module fetch_frontend #(
    parameter int              XLEN       = fetch_frontend_pkg::XLEN,
    parameter logic [XLEN-1:0] BOOT_ADDR  = '0,
    parameter int              IBUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fetch_addr_ready_i,
    output logic             fetch_addr_valid_o,
    output logic [XLEN-1:0]  fetch_addr_o,
    input  logic             fetch_data_valid_i,
    input  logic [31:0]      fetch_data_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             inst_valid_o,
    input  logic             inst_ready_i,
    output logic [XLEN-1:0]  inst_pc_o,
    output logic [31:0]      inst_data_o
);

    import fetch_frontend_pkg::*;

    localparam int              CW      = $clog2(IBUF_DEPTH+1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     data;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] tail_pc_q;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic [CW-1:0]   inflight_q;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   count;
    logic [CW-1:0]   live;
    logic [CW:0]     occupancy;
    logic            may_issue;
    logic            addr_fire;
    logic            resp_fire;
    logic            push;
    logic            pop;
    logic            head_vld;
    entry_t          push_dat;
    entry_t          head_dat;

    assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

    // Credits count buffered entries plus responses still owed to the FIFO;
    // only registered state is used, so a pop frees its slot one cycle later.
    assign live      = inflight_q - drop_q;
    assign occupancy = {1'b0, count} + {1'b0, live};
    assign may_issue = occupancy < (CW+1)'(IBUF_DEPTH);

    // Gating with rstn keeps the request quiet while reset is held.
    assign fetch_addr_valid_o = rstn && fetch_addr_ready_i && may_issue && !redirect_valid_i;
    assign fetch_addr_o       = pc_q;
    assign addr_fire          = fetch_addr_valid_o;

    assign resp_fire = fetch_data_valid_i;
    assign push      = resp_fire && (drop_q == '0) && !redirect_valid_i;
    assign pop       = head_vld && inst_ready_i;
    assign push_dat  = '{pc: tail_pc_q, data: fetch_data_i};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= BOOT_ADDR;
            tail_pc_q <= BOOT_ADDR;
        end else if (redirect_valid_i) begin
            pc_q      <= redirect_pc_aligned;
            tail_pc_q <= redirect_pc_aligned;
        end else begin
            if (addr_fire) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (push) begin
                tail_pc_q <= tail_pc_q + PC_STEP;
            end
        end
    end

    // Responses return in order, so squashing is just a count of words to discard.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            inflight_q <= inflight_q + CW'(addr_fire) - CW'(resp_fire);
            if (redirect_valid_i) begin
                drop_q <= inflight_q - CW'(resp_fire);
            end else if (resp_fire && (drop_q != '0)) begin
                drop_q <= drop_q - CW'(1);
            end
        end
    end

    fetch_ibuf #(
        .DEPTH   (IBUF_DEPTH),
        .entry_t (entry_t)
    ) u_ibuf (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (redirect_valid_i),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_vld_o (head_vld),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    assign inst_valid_o = head_vld;
    assign inst_pc_o    = head_dat.pc;
    assign inst_data_o  = head_dat.data;

    a_inflight_bound: assert property (@(posedge clk) disable iff (!rstn)
        inflight_q <= CW'(IBUF_DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (!rstn)
        drop_q <= inflight_q);
    a_resp_expected: assert property (@(posedge clk) disable iff (!rstn)
        resp_fire |-> (inflight_q != '0));
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rstn)
        fetch_addr_o[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_frontend.sv
// Randomised bench for fetch_frontend against a transaction-level cache and decoder model.
module tb_fetch_frontend;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fetch_addr_ready_i;
    logic        fetch_addr_valid_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_data_valid_i;
    logic [31:0] fetch_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_data_o;

    always #5 clk = ~clk;

    fetch_frontend #(.XLEN(XLEN), .BOOT_ADDR(BOOT), .IBUF_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .fetch_addr_ready_i (fetch_addr_ready_i),
        .fetch_addr_valid_o (fetch_addr_valid_o),
        .fetch_addr_o       (fetch_addr_o),
        .fetch_data_valid_i (fetch_data_valid_i),
        .fetch_data_i       (fetch_data_i),
        .redirect_valid_i   (redirect_valid_i),
        .redirect_pc_i      (redirect_pc_i),
        .inst_valid_o       (inst_valid_o),
        .inst_ready_i       (inst_ready_i),
        .inst_pc_o          (inst_pc_o),
        .inst_data_o        (inst_data_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        cq[$];
    int          cyc, epoch, tot, bufc, lat_min, lat_max;
    bit          cache_en;
    logic [31:0] exp_addr, exp_pc;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        r_rstn, r_ready, r_redir, r_inst_ready;
    logic [31:0] r_redir_pc;

    logic        s_addr_vld, s_inst_vld, s_dvld;
    logic [31:0] s_addr, s_inst_pc, s_inst_dat;
    logic        e_addr_vld, e_inst_vld;
    logic [31:0] e_addr, e_inst_pc, e_inst_dat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234 ^ {a[31:16], 16'h0};
    endfunction

    task automatic model_reset();
        cq.delete();
        exp_addr = BOOT;
        exp_pc   = BOOT;
        tot      = 0;
        bufc     = 0;
        epoch    = 0;
    endtask

    // One clock: drive inputs after the edge, sample mid-cycle, then advance the model.
    task automatic cycle();
        req_t rsp;
        bit   d_vld;
        bit   e_pop;
        @(posedge clk);
        #1;
        rstn               = r_rstn;
        fetch_addr_ready_i = r_ready;
        redirect_valid_i   = r_redir;
        redirect_pc_i      = r_redir_pc;
        inst_ready_i       = r_inst_ready;
        d_vld = 1'b0;
        if (cache_en && cq.size() > 0 && cq[0].due <= cyc) begin
            rsp = cq.pop_front();
            d_vld = 1'b1;
            fetch_data_valid_i = 1'b1;
            fetch_data_i       = mem_word(rsp.addr);
        end else begin
            fetch_data_valid_i = 1'b0;
            fetch_data_i       = $urandom;
        end
        @(negedge clk);
        s_addr_vld = fetch_addr_valid_o;
        s_addr     = fetch_addr_o;
        s_inst_vld = inst_valid_o;
        s_inst_pc  = inst_pc_o;
        s_inst_dat = inst_data_o;
        s_dvld     = d_vld;

        e_addr_vld = r_rstn && r_ready && !r_redir && (tot < DEPTH);
        e_addr     = exp_addr;
        e_inst_vld = (bufc > 0);
        e_inst_pc  = (bufc > 0) ? exp_pc : 32'h0;
        e_inst_dat = (bufc > 0) ? mem_word(exp_pc) : 32'h0;
        e_pop      = e_inst_vld && r_inst_ready && !r_redir;

        if (e_addr_vld) begin
            cq.push_back('{addr: exp_addr, due: cyc + int'($urandom_range(lat_max, lat_min)), epoch: epoch});
            exp_addr += 32'd4;
            tot++;
        end
        if (d_vld && rsp.epoch == epoch && !r_redir) bufc++;
        if (e_pop) begin
            bufc--;
            tot--;
            exp_pc += 32'd4;
        end
        if (r_redir) begin
            epoch++;
            bufc     = 0;
            tot      = 0;
            exp_addr = {r_redir_pc[31:2], 2'b00};
            exp_pc   = exp_addr;
        end
        if (!r_rstn) model_reset();
        cyc++;
    endtask

    task automatic test_reset();
        r_rstn = 1'b0; r_ready = 1'b1; r_redir = 1'b0; r_inst_ready = 1'b1; r_redir_pc = '0;
        cache_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if ({s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat} !== {1'b0, BOOT, 1'b0, 32'h0, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_state: vld=%b addr=%h ivld=%b pc=%h dat=%h, need 0 %h 0 0 0",
                         s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat, BOOT);
            end
        end
    endtask

    task automatic test_issue();
        logic [31:0] want;
        r_rstn = 1'b1; cache_en = 1'b0; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            want = BOOT + 32'(4 * i);
            n_checks++;
            if (i < 4 ? (s_addr_vld !== 1'b1 || s_addr !== want) : (s_addr_vld !== 1'b0)) begin
                n_fail++;
                $display("FAIL issue_seq[%0d]: vld=%b addr=%h, need vld=%b addr=%h",
                         i, s_addr_vld, s_addr, i < 4, want);
            end
            n_checks++;
            if (s_inst_vld !== e_inst_vld) begin
                n_fail++;
                $display("FAIL issue_ivld[%0d]: got %b need %b", i, s_inst_vld, e_inst_vld);
            end
        end
    endtask

    task automatic test_stream();
        int pops = 0;
        cache_en = 1'b1; lat_min = 1; lat_max = 1; r_ready = 1'b1; r_inst_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (i >= 20 && s_inst_vld) pops++;
            n_checks++;
            if ({s_addr_vld, s_addr} !== {e_addr_vld, e_addr}) begin
                n_fail++;
                $display("FAIL stream_issue: got %b/%h need %b/%h", s_addr_vld, s_addr, e_addr_vld, e_addr);
            end
            n_checks++;
            if ({s_inst_vld, s_inst_pc, s_inst_dat} !== {e_inst_vld, e_inst_pc, e_inst_dat}) begin
                n_fail++;
                $display("FAIL stream_inst: got %b/%h/%h need %b/%h/%h",
                         s_inst_vld, s_inst_pc, s_inst_dat, e_inst_vld, e_inst_pc, e_inst_dat);
            end
        end
        n_checks++;
        if (pops !== 10) begin
            n_fail++;
            $display("FAIL stream_rate: %0d pops in 10 cycles, need 10", pops);
        end
    endtask

    task automatic test_backpressure();
        lat_min = 1; lat_max = 3; r_inst_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            n_checks++;
            if ({s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat} !==
                {e_addr_vld, e_addr, e_inst_vld, e_inst_pc, e_inst_dat}) begin
                n_fail++;
                $display("FAIL bp_stall: got %b/%h %b/%h/%h need %b/%h %b/%h/%h",
                         s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat,
                         e_addr_vld, e_addr, e_inst_vld, e_inst_pc, e_inst_dat);
            end
        end
        n_checks++;
        if ({s_addr_vld, s_inst_vld, 32'(bufc)} !== {1'b0, 1'b1, 32'd4}) begin
            n_fail++;
            $display("FAIL bp_full: addr_vld=%b inst_vld=%b buffered=%0d, need 0 1 4", s_addr_vld, s_inst_vld, bufc);
        end
        r_inst_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_checks++;
            if ({s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat} !==
                {e_addr_vld, e_addr, e_inst_vld, e_inst_pc, e_inst_dat}) begin
                n_fail++;
                $display("FAIL bp_drain: got %b/%h %b/%h/%h need %b/%h %b/%h/%h",
                         s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat,
                         e_addr_vld, e_addr, e_inst_vld, e_inst_pc, e_inst_dat);
            end
        end
    endtask

    task automatic run_until_first_pop(input string name, input logic [31:0] want);
        bit seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            cycle();
            n_checks++;
            if ({s_inst_vld, s_inst_pc, s_inst_dat} !== {e_inst_vld, e_inst_pc, e_inst_dat}) begin
                n_fail++;
                $display("FAIL %s_inst: got %b/%h/%h need %b/%h/%h", name,
                         s_inst_vld, s_inst_pc, s_inst_dat, e_inst_vld, e_inst_pc, e_inst_dat);
            end
            if (!seen && s_inst_vld && r_inst_ready) begin
                seen = 1'b1;
                n_checks++;
                if (s_inst_pc !== want) begin
                    n_fail++;
                    $display("FAIL %s_first_pc: got %h need %h", name, s_inst_pc, want);
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_first_pc: no instruction within bound, need %h", name, want);
        end
    endtask

    task automatic test_redirect_inflight();
        r_ready = 1'b0; r_redir = 1'b1; r_redir_pc = 32'h2000;
        cycle();
        r_redir = 1'b0; r_ready = 1'b1; lat_min = 4; lat_max = 4;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_checks++;
            if ({s_addr_vld, s_addr} !== {1'b1, 32'h2000 + 32'(4 * i)}) begin
                n_fail++;
                $display("FAIL redir_setup: got %b/%h need 1/%h", s_addr_vld, s_addr, 32'h2000 + 32'(4 * i));
            end
        end
        r_ready = 1'b0; r_redir = 1'b1; r_redir_pc = 32'h1003;
        cycle();
        r_redir = 1'b0; r_ready = 1'b1; lat_min = 1; lat_max = 1;
        run_until_first_pop("redir_inflight", 32'h1000);
    endtask

    task automatic test_redirect_collide();
        bit hit = 1'b0;
        lat_min = 1; lat_max = 1; r_ready = 1'b1; r_inst_ready = 1'b1;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (bufc > 0 && cq.size() > 0 && cq[0].due <= cyc) begin
                hit = 1'b1;
                r_redir = 1'b1; r_redir_pc = 32'h0000_4000;
            end
            cycle();
            r_redir = 1'b0;
        end
        n_checks++;
        if (!hit || s_dvld !== 1'b1 || s_inst_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_setup: found=%b resp=%b inst_vld=%b, need 1 1 1", hit, s_dvld, s_inst_vld);
        end
        cycle();
        n_checks++;
        if ({s_inst_vld, s_inst_pc} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL collide_empty: inst_vld=%b pc=%h, need 0 0", s_inst_vld, s_inst_pc);
        end
        run_until_first_pop("collide", 32'h0000_4000);
    endtask

    task automatic test_back_to_back();
        lat_min = 2; lat_max = 3; r_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        r_redir = 1'b1; r_redir_pc = 32'h0000_7000;
        cycle();
        r_redir_pc = 32'h0000_9006;
        cycle();
        r_redir = 1'b0;
        run_until_first_pop("b2b", 32'h0000_9004);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            r_ready      = ($urandom_range(3, 0) != 0);
            r_inst_ready = ($urandom_range(9, 0) < 7);
            r_redir      = ($urandom_range(19, 0) == 0);
            r_redir_pc   = $urandom;
            lat_min = 1; lat_max = 3;
            cycle();
            n_checks++;
            if ({s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat} !==
                {e_addr_vld, e_addr, e_inst_vld, e_inst_pc, e_inst_dat}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b/%h %b/%h/%h need %b/%h %b/%h/%h", i,
                         s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat,
                         e_addr_vld, e_addr, e_inst_vld, e_inst_pc, e_inst_dat);
            end
        end
        r_redir = 1'b0;
    endtask

    task automatic test_reset_midstream();
        bit seen = 1'b0;
        r_ready = 1'b1; r_inst_ready = 1'b1; lat_min = 1; lat_max = 2;
        for (int i = 0; i < 8; i++) cycle();
        fetch_data_valid_i = 1'b0;
        @(posedge clk);
        #3;
        rstn = 1'b0; r_rstn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({fetch_addr_valid_o, fetch_addr_o, inst_valid_o, inst_pc_o, inst_data_o} !==
            {1'b0, BOOT, 1'b0, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: vld=%b addr=%h ivld=%b pc=%h dat=%h, need 0 %h 0 0 0",
                     fetch_addr_valid_o, fetch_addr_o, inst_valid_o, inst_pc_o, inst_data_o, BOOT);
        end
        cycle();
        r_rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (!seen && s_addr_vld) begin
                seen = 1'b1;
                n_checks++;
                if (s_addr !== BOOT) begin
                    n_fail++;
                    $display("FAIL restart_addr: got %h need %h", s_addr, BOOT);
                end
            end
            n_checks++;
            if ({s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat} !==
                {e_addr_vld, e_addr, e_inst_vld, e_inst_pc, e_inst_dat}) begin
                n_fail++;
                $display("FAIL restart_stream: got %b/%h %b/%h/%h need %b/%h %b/%h/%h",
                         s_addr_vld, s_addr, s_inst_vld, s_inst_pc, s_inst_dat,
                         e_addr_vld, e_addr, e_inst_vld, e_inst_pc, e_inst_dat);
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL restart_addr: no request after reset release");
        end
    endtask

    initial begin
        rstn = 1'b0; fetch_addr_ready_i = 1'b0; fetch_data_valid_i = 1'b0; fetch_data_i = '0;
        redirect_valid_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
        cyc = 0; lat_min = 1; lat_max = 1;
        model_reset();
        test_reset();
        test_issue();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collide();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
